// File: rtl/serial_pkg.sv
// Shared constants, SCON layout and TX sequencer state encoding for serial_ctrl.
package serial_pkg;

  localparam logic [7:0] SCON_ADDR_DEF = 8'h98;
  localparam logic [7:0] SBUF_ADDR_DEF = 8'h99;

  localparam int SCON_RI  = 0;
  localparam int SCON_TI  = 1;
  localparam int SCON_RB8 = 2;
  localparam int SCON_TB8 = 3;
  localparam int SCON_REN = 4;
  localparam int SCON_SM0 = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX_START = 2'd1,
    ST_TX_BUSY  = 2'd2
  } state_e;

  typedef struct packed {
    logic sm0;
    logic ren;
    logic tb8;
    logic rb8;
    logic ti;
    logic ri;
  } scon_t;

  // Bits 6:5 read as zero.
  function automatic logic [7:0] scon_pack(input scon_t s);
    logic [7:0] p;
    p           = '0;
    p[SCON_SM0] = s.sm0;
    p[SCON_REN] = s.ren;
    p[SCON_TB8] = s.tb8;
    p[SCON_RB8] = s.rb8;
    p[SCON_TI]  = s.ti;
    p[SCON_RI]  = s.ri;
    return p;
  endfunction

  // Last mode-1 count before br toggles: 8 ticks with SMOD=1, 16 with SMOD=0.
  function automatic logic [3:0] baud_wrap(input logic smod);
    return smod ? 4'd7 : 4'd15;
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Mode 0 fixed divider and mode 1 timer1-overflow divider producing br/br_trans.
module serial_baud_gen
  import serial_pkg::*;
#(
  parameter int MODE0_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sm0_i,
  input  logic smod_i,
  input  logic t1_ovf_i,
  output logic br_o,
  output logic br_trans_o
);

  localparam int M0W = (MODE0_HALF > 1) ? $clog2(MODE0_HALF) : 1;

  logic [M0W-1:0] m0_cnt_q, m0_cnt_d;
  logic [3:0]     m1_cnt_q, m1_cnt_d;
  logic           br_q, br_d;
  logic           sm0_prev_q;

  always_comb begin
    m0_cnt_d = m0_cnt_q;
    m1_cnt_d = m1_cnt_q;
    br_d     = br_q;
    // A mode switch restarts both dividers from a clean low phase.
    if (sm0_i != sm0_prev_q) begin
      m0_cnt_d = '0;
      m1_cnt_d = '0;
      br_d     = 1'b0;
    end else if (!sm0_i) begin
      if (m0_cnt_q == M0W'(MODE0_HALF - 1)) begin
        m0_cnt_d = '0;
        br_d     = ~br_q;
      end else begin
        m0_cnt_d = m0_cnt_q + 1'b1;
      end
    end else if (t1_ovf_i) begin
      if (m1_cnt_q >= baud_wrap(smod_i)) begin
        m1_cnt_d = '0;
        br_d     = ~br_q;
      end else begin
        m1_cnt_d = m1_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m0_cnt_q   <= '0;
      m1_cnt_q   <= '0;
      br_q       <= 1'b0;
      sm0_prev_q <= 1'b0;
    end else begin
      m0_cnt_q   <= m0_cnt_d;
      m1_cnt_q   <= m1_cnt_d;
      br_q       <= br_d;
      sm0_prev_q <= sm0_i;
    end
  end

  assign br_o       = br_q;
  assign br_trans_o = br_q;

endmodule

// File: rtl/serial_ctrl.sv
// SCON/SBUF SFR controller, TX start sequencer and baud generation for serial_top.
// Define SERIAL_CTRL_TIMEOUT_EN to abort a TX_BUSY that outlasts TX_TIMEOUT clocks.
module serial_ctrl
  import serial_pkg::*;
#(
  parameter logic [7:0] SCON_ADDR  = SCON_ADDR_DEF,
  parameter logic [7:0] SBUF_ADDR  = SBUF_ADDR_DEF,
  parameter int         MODE0_HALF = 2
`ifdef SERIAL_CTRL_TIMEOUT_EN
  , parameter int       TX_TIMEOUT = 1023
`endif
) (
  input  logic       serial_ctrl_clock_i,
  input  logic       serial_ctrl_reset_i,
  input  logic [7:0] serial_ctrl_sfr_addr_i,
  input  logic       serial_ctrl_sfr_wr_i,
  input  logic       serial_ctrl_sfr_rd_i,
  input  logic [7:0] serial_ctrl_sfr_data_i,
  output logic [7:0] serial_ctrl_sfr_data_o,
  input  logic       serial_ctrl_t1_ovf_i,
  input  logic       serial_ctrl_smod_i,
  input  logic       serial_ctrl_ri_set_i,
  input  logic       serial_ctrl_ti_set_i,
  input  logic       serial_ctrl_rb8_i,
  input  logic [7:0] serial_ctrl_rx_data_i,
  output logic       serial_ctrl_scon0_ri_o,
  output logic       serial_ctrl_scon1_ti_o,
  output logic       serial_ctrl_scon3_tb8_o,
  output logic       serial_ctrl_scon4_ren_o,
  output logic       serial_ctrl_scon7_sm0_o,
  output logic       serial_ctrl_serial_tx_o,
  output logic [7:0] serial_ctrl_data_sbuf_o,
  output logic       serial_ctrl_br_o,
  output logic       serial_ctrl_br_trans_o,
  output logic       serial_ctrl_irq_o,
  output logic       serial_ctrl_busy_o,
  output logic       serial_ctrl_ovr_o
);

  logic clk, rst;
  assign clk = serial_ctrl_clock_i;
  assign rst = serial_ctrl_reset_i;

  state_e     state_q;
  scon_t      scon_q, scon_d;
  logic [7:0] tx_buf_q;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [7:0] rd_data_q;
  logic       tx_pulse_q, busy_q, irq_q;
  logic       ovr_q, ovr_d;
  logic       scon_wr, sbuf_wr, tx_abort;

  assign scon_wr = serial_ctrl_sfr_wr_i && (serial_ctrl_sfr_addr_i == SCON_ADDR);
  assign sbuf_wr = serial_ctrl_sfr_wr_i && (serial_ctrl_sfr_addr_i == SBUF_ADDR);

`ifdef SERIAL_CTRL_TIMEOUT_EN
  localparam int TOW = $clog2(TX_TIMEOUT + 1);
  logic [TOW-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_TX_BUSY) to_cnt_q <= '0;
    else                              to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign tx_abort = (state_q == ST_TX_BUSY) && !serial_ctrl_ti_set_i &&
                    (to_cnt_q == TOW'(TX_TIMEOUT - 1));
`else
  assign tx_abort = 1'b0;
`endif

  // TX sequencer; serial_tx/busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_buf_q   <= '0;
    end else begin
      tx_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sbuf_wr) begin
            tx_buf_q   <= serial_ctrl_sfr_data_i;
            state_q    <= ST_TX_START;
            tx_pulse_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_TX_START: state_q <= ST_TX_BUSY;
        ST_TX_BUSY: begin
          if (serial_ctrl_ti_set_i || tx_abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Software writes first, hardware sets last so they win on collision.
  always_comb begin
    scon_d   = scon_q;
    rx_buf_d = rx_buf_q;
    ovr_d    = ovr_q;
    if (scon_wr) begin
      scon_d.sm0 = serial_ctrl_sfr_data_i[SCON_SM0];
      scon_d.ren = serial_ctrl_sfr_data_i[SCON_REN];
      scon_d.tb8 = serial_ctrl_sfr_data_i[SCON_TB8];
      scon_d.ti  = serial_ctrl_sfr_data_i[SCON_TI];
      scon_d.ri  = serial_ctrl_sfr_data_i[SCON_RI];
      if (!serial_ctrl_sfr_data_i[SCON_RI]) ovr_d = 1'b0;
    end
    if (serial_ctrl_ri_set_i) begin
      scon_d.ri  = 1'b1;
      scon_d.rb8 = serial_ctrl_rb8_i;
      rx_buf_d   = serial_ctrl_rx_data_i;
      if (scon_q.ri) ovr_d = 1'b1;
    end
    if (serial_ctrl_ti_set_i || tx_abort) scon_d.ti = 1'b1;
    if (tx_abort) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scon_q   <= '0;
      rx_buf_q <= '0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      scon_q   <= scon_d;
      rx_buf_q <= rx_buf_d;
      ovr_q    <= ovr_d;
      irq_q    <= scon_q.ri | scon_q.ti;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !serial_ctrl_sfr_rd_i)                 rd_data_q <= '0;
    else if (serial_ctrl_sfr_addr_i == SCON_ADDR)     rd_data_q <= scon_pack(scon_q);
    else if (serial_ctrl_sfr_addr_i == SBUF_ADDR)     rd_data_q <= rx_buf_q;
    else                                              rd_data_q <= '0;
  end

  serial_baud_gen #(
    .MODE0_HALF (MODE0_HALF)
  ) u_baud (
    .clk_i      (clk),
    .rst_i      (rst),
    .sm0_i      (scon_q.sm0),
    .smod_i     (serial_ctrl_smod_i),
    .t1_ovf_i   (serial_ctrl_t1_ovf_i),
    .br_o       (serial_ctrl_br_o),
    .br_trans_o (serial_ctrl_br_trans_o)
  );

  assign serial_ctrl_sfr_data_o  = rd_data_q;
  assign serial_ctrl_scon0_ri_o  = scon_q.ri;
  assign serial_ctrl_scon1_ti_o  = scon_q.ti;
  assign serial_ctrl_scon3_tb8_o = scon_q.tb8;
  assign serial_ctrl_scon4_ren_o = scon_q.ren;
  assign serial_ctrl_scon7_sm0_o = scon_q.sm0;
  assign serial_ctrl_serial_tx_o = tx_pulse_q;
  assign serial_ctrl_data_sbuf_o = tx_buf_q;
  assign serial_ctrl_irq_o       = irq_q;
  assign serial_ctrl_busy_o      = busy_q;
  assign serial_ctrl_ovr_o       = ovr_q;

endmodule

// File: tb/tb_serial_ctrl.sv
// Directed bench for serial_ctrl: transaction-level model compared every cycle, plus literal spot checks.
module tb_serial_ctrl;

  localparam int H  = 2;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst, wr, rd, t1_ovf, smod, ri_set, ti_set, rb8_in;
  logic [7:0] addr, din, rx_data;
  logic [7:0] sfr_q, data_sbuf;
  logic       ri, ti, tb8, ren, sm0, stx, br, br_tr, irq, busy, ovr;
  logic       ovf_en;

  always #5 clk = ~clk;

  serial_ctrl #(
    .SCON_ADDR  (8'h98),
    .SBUF_ADDR  (8'h99),
    .MODE0_HALF (H)
`ifdef SERIAL_CTRL_TIMEOUT_EN
    , .TX_TIMEOUT (TO)
`endif
  ) dut (
    .serial_ctrl_clock_i     (clk),
    .serial_ctrl_reset_i     (rst),
    .serial_ctrl_sfr_addr_i  (addr),
    .serial_ctrl_sfr_wr_i    (wr),
    .serial_ctrl_sfr_rd_i    (rd),
    .serial_ctrl_sfr_data_i  (din),
    .serial_ctrl_sfr_data_o  (sfr_q),
    .serial_ctrl_t1_ovf_i    (t1_ovf),
    .serial_ctrl_smod_i      (smod),
    .serial_ctrl_ri_set_i    (ri_set),
    .serial_ctrl_ti_set_i    (ti_set),
    .serial_ctrl_rb8_i       (rb8_in),
    .serial_ctrl_rx_data_i   (rx_data),
    .serial_ctrl_scon0_ri_o  (ri),
    .serial_ctrl_scon1_ti_o  (ti),
    .serial_ctrl_scon3_tb8_o (tb8),
    .serial_ctrl_scon4_ren_o (ren),
    .serial_ctrl_scon7_sm0_o (sm0),
    .serial_ctrl_serial_tx_o (stx),
    .serial_ctrl_data_sbuf_o (data_sbuf),
    .serial_ctrl_br_o        (br),
    .serial_ctrl_br_trans_o  (br_tr),
    .serial_ctrl_irq_o       (irq),
    .serial_ctrl_busy_o      (busy),
    .serial_ctrl_ovr_o       (ovr)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       mvalid = 1'b0;
  logic       m_ri, m_ti, m_rb8, m_tb8, m_ren, m_sm0, m_sm0_prev, m_ovr, m_irq;
  logic       m_busy, m_pulse, m_rdv, m_bmode, m_smod;
  logic [7:0] m_rx, m_txbuf, m_rd;
  int         m_k, m_novf, m_wait;

  always @(posedge clk) begin
    logic scw, sbw, was_ri, was_busy, was_pulse, abort, fin, pend;
    if (rst) begin
      mvalid = 1'b1;
      {m_ri, m_ti, m_rb8, m_tb8, m_ren, m_sm0, m_sm0_prev, m_ovr, m_irq} = '0;
      {m_busy, m_pulse, m_rdv, m_bmode} = '0;
      m_rx = 8'h00; m_txbuf = 8'h00; m_rd = 8'h00;
      m_k = 0; m_novf = 0; m_wait = 0;
      m_smod = smod;
    end else begin
      scw = wr && addr == 8'h98;
      sbw = wr && addr == 8'h99;
      // read returns values held before this edge
      m_rdv = rd;
      m_rd  = (addr == 8'h98) ? {m_sm0, 2'b00, m_ren, m_tb8, m_rb8, m_ti, m_ri} :
              (addr == 8'h99) ? m_rx : 8'h00;
      m_irq = m_ri | m_ti;
      // baud: time since the last origin (reset or mode switch)
      m_smod = smod;
      pend = (m_sm0 != m_sm0_prev);
      m_sm0_prev = m_sm0;
      if (pend) begin m_k = 0; m_novf = 0; m_bmode = m_sm0; end
      else begin m_k++; if (t1_ovf) m_novf++; end
      // transmit transaction
      was_busy  = m_busy;
      was_pulse = m_pulse;
      abort = 1'b0;
      fin   = was_busy && !was_pulse && ti_set;
`ifdef SERIAL_CTRL_TIMEOUT_EN
      if (was_busy && !was_pulse && !ti_set) begin
        m_wait++;
        if (m_wait == TO) abort = 1'b1;
      end
`endif
      if (fin || abort) m_busy = 1'b0;
      m_pulse = !was_busy && sbw;
      if (m_pulse) begin m_busy = 1'b1; m_txbuf = din; m_wait = 0; end
      // flags
      was_ri = m_ri;
      if (scw) begin
        m_sm0 = din[7]; m_ren = din[4]; m_tb8 = din[3]; m_ti = din[1]; m_ri = din[0];
        if (!din[0]) m_ovr = 1'b0;
      end
      if (ri_set) begin
        m_ri = 1'b1; m_rb8 = rb8_in; m_rx = rx_data;
        if (was_ri) m_ovr = 1'b1;
      end
      if (ti_set || abort) m_ti = 1'b1;
      if (abort) m_ovr = 1'b1;
    end
  end

  function automatic logic exp_br();
    if (m_bmode) return ((m_novf / (m_smod ? 8 : 16)) % 2) != 0;
    return ((m_k / H) % 2) != 0;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("ri", ri, m_ri);
      chk("ti", ti, m_ti);
      chk("tb8", tb8, m_tb8);
      chk("ren", ren, m_ren);
      chk("sm0", sm0, m_sm0);
      chk("ovr", ovr, m_ovr);
      chk("irq", irq, m_irq);
      chk("busy", busy, m_busy);
      chk("serial_tx", stx, m_pulse);
      chk("data_sbuf", data_sbuf, m_txbuf);
      chk("br", br, exp_br());
      chk("br_trans", br_tr, exp_br());
      if (m_rdv) chk("sfr_data", sfr_q, m_rd);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ph;
    ph = 0;
    t1_ovf = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ovf_en) begin t1_ovf = (ph == 2); ph = (ph + 1) % 3; end
      else begin t1_ovf = 1'b0; ph = 0; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr = 1'b1; tick(); wr = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] a);
    addr = a; rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic wait_br_change(input string name, output int t);
    logic b0;
    b0 = br;
    t  = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (br !== b0) begin t = cyc; return; end
    end
    n_chk++; n_fail++;
    $display("FAIL %s: br never toggled within 200 cycles", name);
  endtask

  initial begin
    int t1, t2, t3, pulses;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 8'h00; din = 8'h00;
    smod = 1'b0; ri_set = 1'b0; ti_set = 1'b0; rb8_in = 1'b0; rx_data = 8'h00;
    ovf_en = 1'b0;
    repeat (3) tick();
    chk("lit_reset_busy", busy, 1'b0);
    chk("lit_reset_ri", ri, 1'b0);
    chk("lit_reset_sbuf", data_sbuf, 8'h00);
    chk("lit_reset_br", br, 1'b0);
    rst = 1'b0;

    sfr_write(8'h98, 8'h10);
    chk("lit_ren", ren, 1'b1);
    chk("lit_sm0", sm0, 1'b0);

    wait_br_change("m0_a", t1);
    wait_br_change("m0_b", t2);
    wait_br_change("m0_c", t3);
    chk("lit_m0_half", t2 - t1, 2);
    chk("lit_m0_period", t3 - t1, 4);

    sfr_write(8'h99, 8'h55);
    chk("lit_tx_pulse", stx, 1'b1);
    chk("lit_tx_data", data_sbuf, 8'h55);
    chk("lit_tx_busy", busy, 1'b1);
    tick();
    chk("lit_tx_pulse_end", stx, 1'b0);

    pulses = 0;
    sfr_write(8'h99, 8'hAA);
    if (stx) pulses++;
    repeat (4) begin tick(); if (stx) pulses++; end
    chk("lit_busy_wr_pulses", pulses, 0);
    chk("lit_busy_wr_data", data_sbuf, 8'h55);

    ti_set = 1'b1; tick(); ti_set = 1'b0;
    chk("lit_ti_set", ti, 1'b1);
    chk("lit_ti_idle", busy, 1'b0);
    chk("lit_irq_lag", irq, 1'b0);
    tick();
    chk("lit_irq", irq, 1'b1);

    addr = 8'h98; din = 8'h00; wr = 1'b1; ti_set = 1'b1; tick(); wr = 1'b0; ti_set = 1'b0;
    chk("lit_hw_wins_ti", ti, 1'b1);
    chk("lit_hw_wins_ren", ren, 1'b0);

    sfr_write(8'h98, 8'h10);
    rx_data = 8'hA5; rb8_in = 1'b1; ri_set = 1'b1; tick(); ri_set = 1'b0;
    chk("lit_ri", ri, 1'b1);
    chk("lit_no_ovr", ovr, 1'b0);
    sfr_read(8'h99);
    chk("lit_rd_sbuf", sfr_q, 8'hA5);
    sfr_read(8'h98);
    chk("lit_rd_scon", sfr_q, 8'h15);

    rx_data = 8'h3C; rb8_in = 1'b0; ri_set = 1'b1; tick(); ri_set = 1'b0;
    chk("lit_ovr", ovr, 1'b1);
    sfr_read(8'h99);
    chk("lit_rd_overwrite", sfr_q, 8'h3C);
    sfr_write(8'h98, 8'h10);
    chk("lit_ovr_clear", ovr, 1'b0);

    smod = 1'b1; ovf_en = 1'b1;
    sfr_write(8'h98, 8'h90);
    chk("lit_sm0_set", sm0, 1'b1);
    repeat (2) tick();
    wait_br_change("m1_a", t1);
    wait_br_change("m1_b", t2);
    chk("lit_m1_half", t2 - t1, 24);
    ovf_en = 1'b0;
    sfr_write(8'h98, 8'h10);
    repeat (2) tick();

    sfr_write(8'h99, 8'h12);
    tick();
    chk("lit_mid_busy", busy, 1'b1);
    rst = 1'b1; tick();
    chk("lit_rst_idle", busy, 1'b0);
    addr = 8'h99; din = 8'h34; wr = 1'b1; tick(); wr = 1'b0;
    chk("lit_rst_no_pulse", stx, 1'b0);
    rst = 1'b0; tick();
    chk("lit_rst_no_pulse2", stx, 1'b0);

`ifdef SERIAL_CTRL_TIMEOUT_EN
    sfr_write(8'h99, 8'h77);
    repeat (19) tick();
    chk("lit_to_still_busy", busy, 1'b1);
    repeat (3) tick();
    chk("lit_to_idle", busy, 1'b0);
    chk("lit_to_ti", ti, 1'b1);
    chk("lit_to_ovr", ovr, 1'b1);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/serial_ctrl.md
Name: serial_ctrl

Overview:
SFR-side controller and sequencer for serial_top. It holds the SCON and SBUF registers and turns CPU SBUF writes into one-cycle serial_tx start pulses. It captures RI/TI/RB8 and received data returned by serial_top, and generates the br and br_trans baud ticks for mode 0 and mode 1. It sits between the core SFR bus and serial_top, and raises the serial interrupt request.

Parameters:
SCON_ADDR, 8'h98, SFR address of SCON
SBUF_ADDR, 8'h99, SFR address of SBUF
MODE0_HALF, 2, clocks per half-period of br in mode 0 (2 gives a 4-clock period)
TX_TIMEOUT, 1023, clocks allowed in TX_BUSY before abort (used only with the optional feature)

Ports:
serial_ctrl_clock_i  in  1  core clock
serial_ctrl_reset_i  in  1  synchronous, active-high reset
serial_ctrl_sfr_addr_i  in  8  SFR address
serial_ctrl_sfr_wr_i  in  1  SFR write strobe, one cycle
serial_ctrl_sfr_rd_i  in  1  SFR read strobe, one cycle
serial_ctrl_sfr_data_i  in  8  SFR write data
serial_ctrl_sfr_data_o  out  8  SFR read data; registered, valid the cycle after rd
serial_ctrl_t1_ovf_i  in  1  timer1 overflow tick, one cycle
serial_ctrl_smod_i  in  1  PCON.SMOD: 1 gives divide-by-16, 0 gives divide-by-32
serial_ctrl_ri_set_i  in  1  receive-complete pulse from serial_top
serial_ctrl_ti_set_i  in  1  transmit-complete pulse from serial_top
serial_ctrl_rb8_i  in  1  received bit 8 from serial_top
serial_ctrl_rx_data_i  in  8  received byte from serial_top
serial_ctrl_scon0_ri_o  out  1  SCON.RI
serial_ctrl_scon1_ti_o  out  1  SCON.TI
serial_ctrl_scon3_tb8_o  out  1  SCON.TB8
serial_ctrl_scon4_ren_o  out  1  SCON.REN
serial_ctrl_scon7_sm0_o  out  1  SCON.SM0
serial_ctrl_serial_tx_o  out  1  transmit start pulse, one cycle
serial_ctrl_data_sbuf_o  out  8  TX holding byte to serial_top
serial_ctrl_br_o  out  1  receive baud clock, square wave
serial_ctrl_br_trans_o  out  1  transmit baud clock, square wave
serial_ctrl_irq_o  out  1  RI or TI, registered
serial_ctrl_busy_o  out  1  high while not in IDLE
serial_ctrl_ovr_o  out  1  sticky receive overrun flag

Behaviour:
- Reset: all outputs 0; SCON=0; TX and RX buffers 0; FSM in IDLE; baud counters 0.
- SCON write:
  - Loads bits 7, 4, 3, 1 and 0.
  - Bit 2 (RB8) is hardware-only.
  - A hardware set (ri_set or ti_set) in the same cycle wins over a software clear.
- SCON read returns {sm0, 0, 0, ren, tb8, rb8, ti, ri}.
- SBUF write:
  - In IDLE: latch data into the TX buffer, go to TX_START.
  - Outside IDLE: the write is ignored; the TX buffer is unchanged.
- SBUF read returns the RX buffer.
- FSM states: IDLE, TX_START, TX_BUSY.
  - IDLE: waits for an SBUF write.
  - TX_START: serial_tx_o=1 for exactly one cycle, then TX_BUSY.
  - TX_BUSY: ti_set_i sets TI and returns to IDLE.
  - Latency: SBUF write at cycle N gives serial_tx_o high at N+1.
- Receive:
  - ri_set_i latches rx_data_i into the RX buffer, rb8_i into RB8, and sets RI.
  - Receive is independent of the FSM.
  - If RI is already 1 when ri_set_i arrives: overwrite the data and set ovr_o.
  - ovr_o clears on a write to SCON with bit 0 = 0.
- irq_o = RI | TI, registered, one cycle behind the flags.
- Baud generation, SM0=0 (mode 0):
  - br_o toggles every MODE0_HALF clocks.
  - br_trans_o = br_o.
- Baud generation, SM0=1 (mode 1):
  - A 4-bit counter advances on t1_ovf_i.
  - br_o toggles when the counter wraps at 8 (SMOD=1) or 16 (SMOD=0).
  - br_trans_o = br_o.
- A change of SM0 resets the baud counters and the br phase to 0 in the next cycle.
- A reset asserted mid-transmit returns to IDLE immediately; no serial_tx pulse is emitted.

Optional Feature:
SERIAL_CTRL_TIMEOUT_EN:
- Defined: a counter runs in TX_BUSY. On reaching TX_TIMEOUT without ti_set_i, the FSM returns to IDLE, sets TI, and sets ovr_o.
- Undefined: no counter; TX_BUSY waits indefinitely for ti_set_i.

Decomposition:
- Shared package serial_pkg:
  - SCON/SBUF address constants
  - SCON bit-index constants
  - FSM state encoding (IDLE=2'd0, TX_START=2'd1, TX_BUSY=2'd2)
- One sub-module serial_baud_gen: holds the mode 0/mode 1 divider and produces br_o and br_trans_o.

Test Plan:
- Reset, then write SCON=8'h10 -> ren_o=1, sm0_o=0; br_o period is 4 clocks.
- Write SBUF=8'h55 at cycle N -> data_sbuf_o=8'h55, serial_tx_o high only at N+1, busy_o=1; ti_set pulse -> TI=1, irq_o=1 next cycle, busy_o=0.
- Write SBUF=8'hAA while busy -> data_sbuf_o stays 8'h55, no second serial_tx pulse.
- ri_set with rx_data=8'hA5 and rb8=1 -> SBUF read returns 8'hA5, SCON read returns 8'h15 (ren, rb8, ri); second ri_set with 8'h3C before clear -> ovr_o=1, read returns 8'h3C.
- SCON write of 8'h00 in the same cycle as ti_set -> TI=1 (hardware wins).
- SM0=1, SMOD=1, t1_ovf every 3 clocks -> br_o toggles every 24 clocks. With SERIAL_CTRL_TIMEOUT_EN and TX_TIMEOUT=20, no ti_set -> IDLE after 20 cycles, TI=1, ovr_o=1.
